// File: rtl/wb_uart_tx.sv
// Purpose : capture core write-back words in a FIFO and send each one out as four 8N1 UART bytes, MSB byte first.
// Latency : a word pushed into an empty FIFO while idle is popped one clock later, and tx falls on that same edge.
//           A word takes 40*CLKS_PER_BIT line cycles, then one idle cycle with tx=1 follows it.
// Backpr. : there is no backpressure. A valid word that arrives while the FIFO is full is dropped, and overflow latches.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low
//   en         - capture enable; when low, wb_valid is ignored
//   wb_valid   - qualifies wb_data for one cycle
//   wb_data    - 32-bit write-back value
//   tx         - registered UART serial out, idle high
//   busy       - registered, high while a word is on the line (START/DATA/STOP)
//   fifo_count - words currently queued (one extra bit so full and empty differ)
//   overflow   - sticky drop flag, cleared only by reset
module wb_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          wb_valid,
  input  logic [31:0]                   wb_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Capture FIFO
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Serialiser
  logic [31:0]   r_hold;
  logic [1:0]    r_byte_idx;
  logic [2:0]    r_bit_idx;
  logic [BW-1:0] r_baud;
  logic          r_tx;
  logic          r_busy;

  logic          w_push_req;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_end;
  logic [7:0]    w_cur_byte;
  logic [2:0]    w_bit_nxt;
  logic          w_tx_nxt;

  // Fullness uses the count before the edge. A pop on the same edge does not
  // free a slot for the incoming word.
  assign w_push_req = wb_valid & en;
  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_bit_nxt  = r_bit_idx + 3'd1;

  // Byte 0 is the most significant byte of the held word.
  always_comb begin
    w_cur_byte = r_hold[31:24];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_hold[31:24];
      2'd1:    w_cur_byte = r_hold[23:16];
      2'd2:    w_cur_byte = r_hold[15:8];
      default: w_cur_byte = r_hold[7:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next line level. tx is registered, so the level for the
  // state being entered is computed here and loaded on the same edge as the
  // state change.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_pop) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = w_cur_byte[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt    = w_cur_byte[w_bit_nxt];
          end
        end
      end
      default: begin // S_STOP
        if (w_baud_end) begin
          if (r_byte_idx != 2'd3) begin
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
    endcase
  end

  // FIFO storage is not reset, because the pointers and count define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_baud     <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_hold     <= r_mem[r_rd_ptr];
        r_byte_idx <= '0;
      end else if ((r_state == S_STOP) && w_baud_end && (r_byte_idx != 2'd3)) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end

      // The baud counter stays at zero while idle. Every state change happens
      // on a wrap, so each new bit period starts counting from 0.
      if ((r_state == S_IDLE) || w_baud_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BW'(1);
      end

      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_baud_end) begin
        r_bit_idx <= w_bit_nxt;
      end

      r_tx   <= w_tx_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Testbench for wb_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A timeline model predicts tx, busy, fifo_count and overflow for every cycle.
module tb_wb_uart_tx;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  wb_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a queue of accepted words, the word on the line, and the
  // number of line cycles it still has to run.
  logic [31:0] m_q[$];
  logic [31:0] m_cur = '0;
  int          m_rem = 0;
  logic        m_ovf = 1'b0;

  int busy_cycles = 0;
  int peak_count  = 0;

  // Expected line level, computed from the position inside the 40-slot word.
  function automatic logic model_tx();
    int t, bi, sl;
    logic [31:0] w;
    if (m_rem == 0) return 1'b1;
    t  = 40 * C - m_rem;
    bi = t / (10 * C);
    sl = (t % (10 * C)) / C;
    if (sl == 0) return 1'b0;
    if (sl == 9) return 1'b1;
    w = m_cur >> (8 * (3 - bi));
    return w[sl - 1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic e, input logic r);
    int sz;
    logic pop, acc;
    wb_valid = v;
    wb_data  = d;
    en       = e;
    reset    = r;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      sz  = m_q.size();
      pop = (m_rem == 0) && (sz > 0);
      acc = v && e && (sz < D);
      if (v && e && (sz >= D)) m_ovf = 1'b1;
      if (pop) begin
        m_cur = m_q.pop_front();
        m_rem = 40 * C;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (acc) m_q.push_back(d);
    end
    #1;
    check("tx", tx, model_tx());
    check("busy", busy, (m_rem > 0));
    check("fifo_count", fifo_count, m_q.size());
    check("overflow", overflow, m_ovf);
    if (busy === 1'b1) busy_cycles++;
    if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b1, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((m_rem > 0 || m_q.size() > 0) && k < budget) begin
      step(1'b0, $urandom, 1'b1, 1'b1);
      k++;
    end
    idle(2);
    check("drain_busy", busy, 1'b0);
    check("drain_count", fifo_count, 0);
  endtask

  initial begin
    wb_valid = 1'b0;
    wb_data  = '0;
    en       = 1'b1;
    reset    = 1'b0;

    // Reset
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("reset_tx", tx, 1'b1);
    check("reset_count", fifo_count, 0);

    // One word; the start bit must appear on the next edge
    busy_cycles = 0;
    step(1'b1, 32'hA5C3_0F81, 1'b1, 1'b1);
    check("t1_tx_before_pop", tx, 1'b1);
    idle(1);
    check("t1_start_bit", tx, 1'b0);
    drain(300);
    check("t1_line_cycles", busy_cycles, 40 * C);

    // Two words pushed back to back
    peak_count = 0;
    step(1'b1, 32'h0000_0001, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain(600);
    check("t2_peak_count", peak_count, 1);

    // Six consecutive pushes; the sixth is dropped
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b1, 1'b1);
    check("t3_count_full", fifo_count, D);
    check("t3_overflow", overflow, 1'b1);
    drain(1200);
    check("t3_overflow_sticky", overflow, 1'b1);

    // While en is low, wb_valid pulses are ignored
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b1);
      step(1'b0, $urandom, 1'b0, 1'b1);
    end
    check("t4_count", fifo_count, 0);
    check("t4_overflow", overflow, 1'b0);

    // Reset asserted during the data bits of byte 2
    step(1'b1, $urandom, 1'b1, 1'b1);
    idle(1 + 20 * C + 2 * C + 2);
    check("t5_busy_mid", busy, 1'b1);
    step(1'b0, $urandom, 1'b1, 1'b0);
    check("t5_tx_after_reset", tx, 1'b1);
    check("t5_busy_after_reset", busy, 1'b0);
    idle(60);
    check("t5_tx_quiet", tx, 1'b1);

    // The FIFO is full on the edge where the FSM pops; the push is dropped
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b1);
    check("t6_full", fifo_count, D);
    check("t6_no_ovf_yet", overflow, 1'b0);
    for (int k = 0; k < 400 && m_rem > 0; k++) idle(1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    check("t6_count_dec", fifo_count, D - 1);
    check("t6_overflow", overflow, 1'b1);
    drain(1500);

    // Random traffic
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) != 0), 1'b1);
    drain(2500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
